motor_cmd_scheduler: RTL and testbench
======================================

MOTOR_CMD_SCHEDULER -- requirements
Module: motor_cmd_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 250000000, brake-hold length of a dwell stop in clk cycles (legal range 1..2^CNT_W-1).
REQ-002 Parameter TURN_CYCLES, default 50000000, length of a timed left turn in clk cycles (legal range 1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 30, width of the shared interval counter.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cmd_valid  in  1  one-cycle command strobe from the UART decode logic.
REQ-007 cmd_op  in  3  command: 0 STOP, 1 FOLLOW, 2 TURN, 3 DWELL, 4-7 reserved.
REQ-008 lt1, lt2, lt3  in  1 each  line sensors: left, centre, right; already synchronised.
REQ-009 m1, m2, m3, m4  out  1 each  registered H-bridge direction bits.
REQ-010 busy  out  1  high while in TURN or DWELL.
REQ-011 done  out  1  one-cycle pulse when a TURN or DWELL interval completes.
REQ-012 cmd_drop  out  1  one-cycle pulse when an accepted strobe is discarded.
REQ-013 state  out  2  current state encoding: IDLE=0, FOLLOW=1, TURN=2, DWELL=3.

Function
REQ-014 Motor patterns {m1,m2,m3,m4} SHALL be: FWD=1001, RIGHT=0101, LEFT=1010, BRAKE=1111.
REQ-015 IDLE SHALL drive BRAKE; DWELL SHALL drive BRAKE; TURN SHALL drive LEFT.
REQ-016 FOLLOW SHALL drive, by priority: lt2 -> FWD; else lt1 -> RIGHT; else lt3 -> LEFT; else lost-line behaviour per REQ-031.
REQ-017 State, counter and m1..m4 SHALL update on the same clk edge; m1..m4 reflect the next state and the sensors sampled at that edge (1-cycle latency from cmd_valid to motor change).
REQ-018 STOP SHALL move any state to IDLE on the next edge, abort any running interval, and never raise done.
REQ-019 FOLLOW from IDLE or FOLLOW SHALL enter or stay in FOLLOW.
REQ-020 TURN or DWELL from IDLE or FOLLOW SHALL enter that state with counter cleared to 0.
REQ-021 While busy, any non-STOP command SHALL be discarded with cmd_drop=1 for one cycle; state and counter are unchanged.
REQ-022 Reserved cmd_op values SHALL be discarded with cmd_drop=1 in every state.
REQ-023 Counter SHALL increment once per cycle in TURN/DWELL; when counter == interval-1, the next edge SHALL enter FOLLOW, clear counter, and set done=1 for exactly one cycle.
REQ-024 TURN SHALL therefore drive LEFT for exactly TURN_CYCLES cycles and DWELL SHALL drive BRAKE for exactly DWELL_CYCLES cycles.
REQ-025 STOP arriving on the same edge as interval completion SHALL win: IDLE, done=0.
REQ-026 Counter SHALL never wrap; it is compared for equality only and cleared on every state entry.
REQ-027 Sensors SHALL be ignored in IDLE, TURN and DWELL.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, m1..m4=1111, counter=0, busy=0, done=0, cmd_drop=0; cmd_valid is ignored.
REQ-029 rst asserted mid-TURN/DWELL SHALL abort the interval with no done pulse.
REQ-030 The first edge after rst deasserts SHALL process cmd_valid normally.

Configuration
REQ-031 Macro LINE_LOST_HOLD_EN: when defined, FOLLOW with lt1=lt2=lt3=0 SHALL hold the previous m1..m4 value; when undefined, it SHALL drive BRAKE.
REQ-032 No other behaviour SHALL depend on LINE_LOST_HOLD_EN.

Verification (DWELL_CYCLES=8, TURN_CYCLES=4)
REQ-033 rst held 3 cycles, then cmd_valid with cmd_op=1 and lt2=1 -> m=1111 during reset, state=1 and m=1001 one edge after the strobe.
REQ-034 FOLLOW with cmd_op=3 strobe -> BRAKE for exactly 8 cycles, done pulses once, then state=1 and m tracks sensors.
REQ-035 cmd_op=2 strobe, then cmd_op=1 strobe at cycle 2 -> cmd_drop pulse; LEFT held 4 cycles total; done pulses once.
REQ-036 DWELL, with STOP issued on the completion edge (counter=7) -> state=0, m=1111, done stays 0.
REQ-037 FOLLOW with lt=000 after lt1=1 -> m=0101 held with LINE_LOST_HOLD_EN; m=1111 without it.
REQ-038 rst=1 at DWELL counter=3 -> IDLE, done=0, counter=0; cmd_op=5 strobe afterwards -> cmd_drop, state stays 0.

Source files
------------

// File: rtl/motor_cmd_scheduler.sv
// Line-follower command scheduler: IDLE/FOLLOW/TURN/DWELL with a shared interval counter.
// Optional macro LINE_LOST_HOLD_EN: FOLLOW holds the last motor pattern when all sensors read 0.
module motor_cmd_scheduler #(
   parameter int DWELL_CYCLES = 250000000,
   parameter int TURN_CYCLES  = 50000000,
   parameter int CNT_W        = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   input  logic       lt1,
   input  logic       lt2,
   input  logic       lt3,
   output logic       m1,
   output logic       m2,
   output logic       m3,
   output logic       m4,
   output logic       busy,
   output logic       done,
   output logic       cmd_drop,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FOLLOW = 2'd1,
      S_TURN   = 2'd2,
      S_DWELL  = 2'd3
   } state_e;

   localparam logic [3:0] M_FWD   = 4'b1001;
   localparam logic [3:0] M_RIGHT = 4'b0101;
   localparam logic [3:0] M_LEFT  = 4'b1010;
   localparam logic [3:0] M_BRAKE = 4'b1111;

   localparam logic [2:0] OP_STOP   = 3'd0;
   localparam logic [2:0] OP_FOLLOW = 3'd1;
   localparam logic [2:0] OP_TURN   = 3'd2;
   localparam logic [2:0] OP_DWELL  = 3'd3;

   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       m_q, m_d;
   logic             done_q, done_d;
   logic             drop_q, drop_d;
   logic             busy_w;
   logic [CNT_W-1:0] last_w;
   logic [3:0]       lost_m_w;

   assign busy_w = (state_q == S_TURN) || (state_q == S_DWELL);
   assign last_w = (state_q == S_TURN) ? TURN_LAST : DWELL_LAST;

`ifdef LINE_LOST_HOLD_EN
   assign lost_m_w = m_q;
`else
   assign lost_m_w = M_BRAKE;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      drop_d  = 1'b0;
      m_d     = M_BRAKE;

      if (busy_w) begin
         cnt_d = cnt_q + CNT_ONE;
         if (cnt_q == last_w) begin
            state_d = S_FOLLOW;
            cnt_d   = '0;
            done_d  = 1'b1;
         end
      end

      // A command overrides interval completion only when it is accepted (STOP always is).
      if (cmd_valid) begin
         case (cmd_op)
            OP_STOP: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
            OP_FOLLOW: begin
               if (busy_w) begin
                  drop_d = 1'b1;
               end else begin
                  state_d = S_FOLLOW;
                  cnt_d   = '0;
               end
            end
            OP_TURN, OP_DWELL: begin
               if (busy_w) begin
                  drop_d = 1'b1;
               end else begin
                  state_d = (cmd_op == OP_TURN) ? S_TURN : S_DWELL;
                  cnt_d   = '0;
               end
            end
            default: drop_d = 1'b1;
         endcase
      end

      case (state_d)
         S_TURN: m_d = M_LEFT;
         S_FOLLOW: begin
            if (lt2)      m_d = M_FWD;
            else if (lt1) m_d = M_RIGHT;
            else if (lt3) m_d = M_LEFT;
            else          m_d = lost_m_w;
         end
         default: m_d = M_BRAKE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         m_q     <= M_BRAKE;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign {m1, m2, m3, m4} = m_q;
   assign busy             = busy_w;
   assign done             = done_q;
   assign cmd_drop         = drop_q;
   assign state            = state_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler with a countdown-based reference model checked every cycle.
module tb_motor_cmd_scheduler;

   localparam int DWELL = 8;
   localparam int TURN  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic       lt1 = 1'b0, lt2 = 1'b0, lt3 = 1'b0;
   logic       m1, m2, m3, m4, busy, done, cmd_drop;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   motor_cmd_scheduler #(
      .DWELL_CYCLES(DWELL),
      .TURN_CYCLES (TURN),
      .CNT_W       (30)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_op   (cmd_op),
      .lt1      (lt1),
      .lt2      (lt2),
      .lt3      (lt3),
      .m1       (m1),
      .m2       (m2),
      .m3       (m3),
      .m4       (m4),
      .busy     (busy),
      .done     (done),
      .cmd_drop (cmd_drop),
      .state    (state)
   );

   always #5 clk = ~clk;

   // Reference model: mode plus remaining cycles of the running interval.
   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] rem;
      logic [3:0]  m;
      logic        done;
      logic        drop;
   } model_t;

   model_t mdl;
   logic   live = 1'b0;

   function automatic model_t model_next(input model_t c, input logic r, input logic v,
                                         input logic [2:0] op, input logic l1, input logic l2,
                                         input logic l3);
      model_t n;
      logic   was_busy;
      n      = c;
      n.done = 1'b0;
      n.drop = 1'b0;
      if (r) begin
         n.st  = 2'd0;
         n.rem = 32'd0;
         n.m   = 4'hF;
         return n;
      end
      was_busy = (c.st == 2'd2) || (c.st == 2'd3);
      if (was_busy) begin
         n.rem = c.rem - 32'd1;
         if (c.rem == 32'd1) begin
            n.st   = 2'd1;
            n.done = 1'b1;
         end
      end
      if (v) begin
         if (op == 3'd0) begin
            n.st   = 2'd0;
            n.rem  = 32'd0;
            n.done = 1'b0;
         end else if (op > 3'd3 || was_busy) begin
            n.drop = 1'b1;
         end else if (op == 3'd1) begin
            n.st = 2'd1;
         end else begin
            n.st  = op[1:0];
            n.rem = (op == 3'd2) ? TURN : DWELL;
         end
      end
      case (n.st)
         2'd2: n.m = 4'b1010;
         2'd1: begin
            if (l2)      n.m = 4'b1001;
            else if (l1) n.m = 4'b0101;
            else if (l3) n.m = 4'b1010;
            else begin
`ifdef LINE_LOST_HOLD_EN
               n.m = c.m;
`else
               n.m = 4'hF;
`endif
            end
         end
         default: n.m = 4'hF;
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      mdl  <= model_next(mdl, rst, cmd_valid, cmd_op, lt1, lt2, lt3);
      live <= 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (live) begin
         check("cyc_motor", {28'd0, m1, m2, m3, m4}, {28'd0, mdl.m});
         check("cyc_state", {30'd0, state}, {30'd0, mdl.st});
         check("cyc_busy", {31'd0, busy}, {31'd0, mdl.st[1]});
         check("cyc_done", {31'd0, done}, {31'd0, mdl.done});
         check("cyc_drop", {31'd0, cmd_drop}, {31'd0, mdl.drop});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [2:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic set_lt(input logic [2:0] b);
      {lt1, lt2, lt3} = b;
   endtask

   function automatic logic [3:0] mot();
      return {m1, m2, m3, m4};
   endfunction

   initial begin
      int cyc;
      int dn;
      logic [3:0] lost_exp;

      // Reset held three cycles; a strobe during reset must be ignored.
      set_lt(3'b010);
      tick();
      tick();
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      tick();
      cmd_valid = 1'b0;
      check("rst_motor", {28'd0, mot()}, 32'hF);
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_flags", {29'd0, busy, done, cmd_drop}, 32'd0);

      rst = 1'b0;
      strobe(3'd1);
      check("follow_state", {30'd0, state}, 32'd1);
      check("follow_fwd", {28'd0, mot()}, 32'h9);

      set_lt(3'b100); tick();
      check("follow_right", {28'd0, mot()}, 32'h5);
      set_lt(3'b001); tick();
      check("follow_left", {28'd0, mot()}, 32'hA);
      set_lt(3'b111); tick();
      check("follow_prio", {28'd0, mot()}, 32'h9);
      set_lt(3'b101); tick();
      check("follow_prio13", {28'd0, mot()}, 32'h5);

      // DWELL from FOLLOW: brake for exactly DWELL cycles, one done pulse.
      set_lt(3'b010);
      strobe(3'd3);
      check("dwell_enter", {28'd0, mot()}, 32'hF);
      cyc = 1;
      dn  = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) dn++;
         if (state == 2'd3) cyc++;
         else break;
      end
      check("dwell_len", cyc, DWELL);
      check("dwell_done_cnt", dn, 1);
      check("dwell_exit_motor", {28'd0, mot()}, 32'h9);
      tick();
      check("dwell_done_one", {31'd0, done}, 32'd0);

      // TURN with a FOLLOW strobe on its second cycle: dropped, LEFT held TURN cycles.
      strobe(3'd2);
      check("turn_left", {28'd0, mot()}, 32'hA);
      tick();
      strobe(3'd1);
      check("turn_drop", {31'd0, cmd_drop}, 32'd1);
      check("turn_state_kept", {30'd0, state}, 32'd2);
      cyc = 3;
      dn  = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) dn++;
         if (state == 2'd2) cyc++;
         else break;
      end
      check("turn_len", cyc, TURN);
      check("turn_done_cnt", dn, 1);

      // STOP on the DWELL completion edge wins.
      tick();
      strobe(3'd3);
      for (int i = 0; i < DWELL - 1; i++) tick();
      strobe(3'd0);
      check("stop_win_state", {30'd0, state}, 32'd0);
      check("stop_win_motor", {28'd0, mot()}, 32'hF);
      check("stop_win_done", {31'd0, done}, 32'd0);
      tick();
      check("stop_win_done2", {31'd0, done}, 32'd0);

      // Lost line after a RIGHT correction.
`ifdef LINE_LOST_HOLD_EN
      lost_exp = 4'b0101;
`else
      lost_exp = 4'b1111;
`endif
      set_lt(3'b100);
      strobe(3'd1);
      check("lost_pre", {28'd0, mot()}, 32'h5);
      set_lt(3'b000); tick();
      check("lost_line", {28'd0, mot()}, {28'd0, lost_exp});
      tick();
      check("lost_line2", {28'd0, mot()}, {28'd0, lost_exp});

      // Reserved op in FOLLOW, then reset in mid DWELL.
      strobe(3'd6);
      check("resv_follow_drop", {31'd0, cmd_drop}, 32'd1);
      check("resv_follow_state", {30'd0, state}, 32'd1);
      set_lt(3'b010);
      strobe(3'd3);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("midrst_state", {30'd0, state}, 32'd0);
      check("midrst_motor", {28'd0, mot()}, 32'hF);
      rst = 1'b0;
      for (int i = 0; i < DWELL + 2; i++) begin
         tick();
         check("midrst_no_done", {31'd0, done}, 32'd0);
      end
      strobe(3'd5);
      check("resv_idle_drop", {31'd0, cmd_drop}, 32'd1);
      check("resv_idle_state", {30'd0, state}, 32'd0);

      // STOP aborting a TURN.
      strobe(3'd2);
      tick();
      strobe(3'd0);
      check("turn_stop_state", {30'd0, state}, 32'd0);
      check("turn_stop_busy", {31'd0, busy}, 32'd0);
      tick(); tick(); tick(); tick();
      check("turn_stop_idle", {30'd0, state}, 32'd0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
